// File: rtl/alu_muldiv_unit.sv
// alu_muldiv_unit: handshaked integer execute unit.
//   Single-cycle ALU/branch ops plus iterative RV32M multiply/divide/remainder.
//   Optional build macro ALU_FAST_MUL_EN: multiplies use a combinational
//   2*XLEN product with single-cycle latency; divide stays iterative.
// Ports:
//   clk, rst           clock (rising edge), async active-high reset
//   in_valid/in_ready  request handshake; op, rs1, rs2 sampled at accept
//   flush              synchronous abort of any in-flight or held op
//   out_valid/out_ready result handshake; result, branch_taken held in DONE
//   busy               iterative op in progress
module alu_muldiv_unit #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            branch_taken,
  output logic            busy
);

  localparam int CNT_W = $clog2(XLEN + 1);

  localparam logic [4:0] OP_ADD    = 5'd1;
  localparam logic [4:0] OP_SUB    = 5'd2;
  localparam logic [4:0] OP_XOR    = 5'd3;
  localparam logic [4:0] OP_OR     = 5'd4;
  localparam logic [4:0] OP_AND    = 5'd5;
  localparam logic [4:0] OP_SLL    = 5'd6;
  localparam logic [4:0] OP_SRL    = 5'd7;
  localparam logic [4:0] OP_SRA    = 5'd8;
  localparam logic [4:0] OP_SLT    = 5'd9;
  localparam logic [4:0] OP_SLTU   = 5'd10;
  localparam logic [4:0] OP_BEQ    = 5'd11;
  localparam logic [4:0] OP_BNE    = 5'd12;
  localparam logic [4:0] OP_BLT    = 5'd13;
  localparam logic [4:0] OP_BGE    = 5'd14;
  localparam logic [4:0] OP_BLTU   = 5'd15;
  localparam logic [4:0] OP_BGEU   = 5'd16;
  localparam logic [4:0] OP_JAL    = 5'd17;
  localparam logic [4:0] OP_LUI    = 5'd18;
  localparam logic [4:0] OP_MUL    = 5'd19;
  localparam logic [4:0] OP_MULH   = 5'd20;
  localparam logic [4:0] OP_MULHSU = 5'd21;
  localparam logic [4:0] OP_MULHU  = 5'd22;
  localparam logic [4:0] OP_DIV    = 5'd23;
  localparam logic [4:0] OP_DIVU   = 5'd24;
  localparam logic [4:0] OP_REM    = 5'd25;
  localparam logic [4:0] OP_REMU   = 5'd26;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              branch_q, branch_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [4:0]        op_q, op_d;
  logic [XLEN-1:0]   acc_q, acc_d;    // product high half / partial remainder
  logic [XLEN-1:0]   lo_q, lo_d;      // multiplier, then product low / quotient
  logic [XLEN-1:0]   opb_q, opb_d;    // multiplicand / divisor magnitude
  logic [XLEN-1:0]   rs1_q, rs1_d;    // original dividend for REM by zero
  logic              neg_q, neg_d;    // product / quotient sign
  logic              negr_q, negr_d;  // remainder sign
  logic              div0_q, div0_d;

  // Operand decode for the request on the input port
  logic            is_mul_in, is_div_in, iter_in;
  logic            a_signed_in, b_signed_in, a_neg_in, b_neg_in;
  logic [XLEN-1:0] mag_a, mag_b;
  logic [SHAMT_W-1:0] shamt;

  assign is_mul_in   = (op >= OP_MUL) && (op <= OP_MULHU);
  assign is_div_in   = (op >= OP_DIV) && (op <= OP_REMU);
  assign a_signed_in = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
                       (op == OP_DIV) || (op == OP_REM);
  assign b_signed_in = (op == OP_MUL) || (op == OP_MULH) ||
                       (op == OP_DIV) || (op == OP_REM);
  assign a_neg_in    = a_signed_in && rs1[XLEN-1];
  assign b_neg_in    = b_signed_in && rs2[XLEN-1];
  assign mag_a       = a_neg_in ? (~rs1 + 1'b1) : rs1;
  assign mag_b       = b_neg_in ? (~rs2 + 1'b1) : rs2;
  assign shamt       = rs2[SHAMT_W-1:0];

`ifdef ALU_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  assign fast_prod = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
  assign iter_in   = is_div_in;
`else
  assign iter_in   = is_mul_in || is_div_in;
`endif

  // Apply the sign to the magnitude product and pick the requested half
  function automatic logic [XLEN-1:0] mul_pick(input logic [4:0] f_op,
                                               input logic [2*XLEN-1:0] mag_prod,
                                               input logic f_neg);
    logic [2*XLEN-1:0] prod;
    prod = f_neg ? (~mag_prod + 1'b1) : mag_prod;
    return (f_op == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  endfunction

  function automatic logic [XLEN-1:0] div_pick(input logic [4:0] f_op,
                                               input logic [XLEN-1:0] q,
                                               input logic [XLEN-1:0] r,
                                               input logic f_negq,
                                               input logic f_negr,
                                               input logic f_div0,
                                               input logic [XLEN-1:0] f_a);
    logic is_rem;
    is_rem = (f_op == OP_REM) || (f_op == OP_REMU);
    if (f_div0) return is_rem ? f_a : '1;
    else if (is_rem) return f_negr ? (~r + 1'b1) : r;
    else return f_negq ? (~q + 1'b1) : q;
  endfunction

  // Single-cycle ALU / branch datapath
  logic [XLEN-1:0] base_res;
  logic            base_br;

  always_comb begin
    base_res = '0;
    base_br  = 1'b0;
    case (op)
      OP_ADD:  base_res = rs1 + rs2;
      OP_SUB:  base_res = rs1 - rs2;
      OP_XOR:  base_res = rs1 ^ rs2;
      OP_OR:   base_res = rs1 | rs2;
      OP_AND:  base_res = rs1 & rs2;
      OP_SLL:  base_res = rs1 << shamt;
      OP_SRL:  base_res = rs1 >> shamt;
      OP_SRA:  base_res = $unsigned($signed(rs1) >>> shamt);
      OP_SLT:  base_res = {{(XLEN-1){1'b0}}, $signed(rs1) < $signed(rs2)};
      OP_SLTU: base_res = {{(XLEN-1){1'b0}}, rs1 < rs2};
      OP_BEQ:  base_br  = (rs1 == rs2);
      OP_BNE:  base_br  = (rs1 != rs2);
      OP_BLT:  base_br  = ($signed(rs1) < $signed(rs2));
      OP_BGE:  base_br  = ($signed(rs1) >= $signed(rs2));
      OP_BLTU: base_br  = (rs1 < rs2);
      OP_BGEU: base_br  = (rs1 >= rs2);
      OP_JAL:  base_res = rs1 + rs2;
      OP_LUI:  base_res = rs2 << 12;
`ifdef ALU_FAST_MUL_EN
      OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU:
               base_res = mul_pick(op, fast_prod, a_neg_in ^ b_neg_in);
`endif
      default: ;
    endcase
  end

  // One iteration of the shared shift-add / restoring-divide datapath
  logic            is_div_q;
  logic [XLEN:0]   mul_sum, div_r, div_diff;
  logic [XLEN-1:0] step_acc, step_lo, final_res;

  assign is_div_q = (op_q >= OP_DIV);
  assign mul_sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
  assign div_r    = {acc_q, lo_q[XLEN-1]};
  assign div_diff = div_r - {1'b0, opb_q};

  always_comb begin
    if (is_div_q) begin
      if (!div_diff[XLEN]) begin
        step_acc = div_diff[XLEN-1:0];
        step_lo  = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        step_acc = div_r[XLEN-1:0];
        step_lo  = {lo_q[XLEN-2:0], 1'b0};
      end
    end else begin
      step_acc = mul_sum[XLEN:1];
      step_lo  = {mul_sum[0], lo_q[XLEN-1:1]};
    end
  end

  // Final result is taken from the last iteration's output so that DONE is
  // reached on the same edge the counter reaches zero.
  assign final_res = is_div_q
      ? div_pick(op_q, step_lo, step_acc, neg_q, negr_q, div0_q, rs1_q)
      : mul_pick(op_q, {step_acc, step_lo}, neg_q);

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    branch_d = branch_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    acc_d    = acc_q;
    lo_d     = lo_q;
    opb_d    = opb_q;
    rs1_d    = rs1_q;
    neg_d    = neg_q;
    negr_d   = negr_q;
    div0_d   = div0_q;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (iter_in) begin
              op_d   = op;
              rs1_d  = rs1;
              neg_d  = a_neg_in ^ b_neg_in;
              negr_d = a_neg_in;
              div0_d = (rs2 == '0);
              acc_d  = '0;
              lo_d   = is_div_in ? mag_a : mag_b;
              opb_d  = is_div_in ? mag_b : mag_a;
              cnt_d  = CNT_W'(XLEN);
              state_d = BUSY;
            end else begin
              result_d = base_res;
              branch_d = base_br;
              state_d  = DONE;
            end
          end
        end
        BUSY: begin
          acc_d = step_acc;
          lo_d  = step_lo;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            result_d = final_res;
            branch_d = 1'b0;
            state_d  = DONE;
          end
        end
        DONE: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      result_q <= '0;
      branch_q <= 1'b0;
      cnt_q    <= '0;
      op_q     <= '0;
      acc_q    <= '0;
      lo_q     <= '0;
      opb_q    <= '0;
      rs1_q    <= '0;
      neg_q    <= 1'b0;
      negr_q   <= 1'b0;
      div0_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      branch_q <= branch_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      lo_q     <= lo_d;
      opb_q    <= opb_d;
      rs1_q    <= rs1_d;
      neg_q    <= neg_d;
      negr_q   <= negr_d;
      div0_q   <= div0_d;
    end
  end

  assign in_ready     = (state_q == IDLE) && !rst;
  assign out_valid    = (state_q == DONE);
  assign busy         = (state_q == BUSY);
  assign result       = result_q;
  assign branch_taken = branch_q;

endmodule

// File: tb/tb_alu_muldiv_unit.sv
module tb_alu_muldiv_unit;

  localparam int DIV_LAT = 33;
`ifdef ALU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  op = '0;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        branch_taken;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  alu_muldiv_unit #(.XLEN(32), .SHAMT_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rs1(rs1), .rs2(rs2), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .branch_taken(branch_taken), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a request and return 1 time unit after the accepting edge.
  task automatic issue(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; rs1 = a; rs2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; op = 5'd3; rs1 = 32'hDEAD_BEEF; rs2 = 32'h1234_5678;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [4:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input logic exp_br, input int exp_lat);
    int lat;
    issue(o, a, b);
    wait_valid(lat);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_res"}, result, exp_res);
    chk({tag, "_br"}, 32'(branch_taken), 32'(exp_br));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_idle"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int cnt;
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_branch", 32'(branch_taken), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Back-pressure: ADD 3+4 held for 5 cycles while a competing request waits
    issue(5'd1, 32'd3, 32'd4);
    chk("bp_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      op = 5'd2; rs1 = 32'd9; rs2 = 32'd1; in_valid = 1'b1;
      chk("bp_hold_res", result, 32'd7);
      chk("bp_hold_rdy", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("bp_last_res", result, 32'd7);
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_rdy_after", 32'(in_ready), 32'd1);
    chk("bp_valid_after", 32'(out_valid), 32'd0);

    // Base ops and signed corner cases
    run_op("sub",   5'd2,  32'd10,        32'd15,        32'hFFFF_FFFB, 1'b0, 1);
    run_op("slt",   5'd9,  32'hFFFF_FFFF, 32'd1,         32'd1,         1'b0, 1);
    run_op("sltu",  5'd10, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b0, 1);
    run_op("bge",   5'd14, 32'hFFFF_FFFB, 32'd3,         32'd0,         1'b0, 1);
    run_op("bgeu",  5'd16, 32'hFFFF_FFFB, 32'd3,         32'd0,         1'b1, 1);
    run_op("beq",   5'd11, 32'd42,        32'd42,        32'd0,         1'b1, 1);
    run_op("sra",   5'd8,  32'h8000_0000, 32'h21,        32'hC000_0000, 1'b0, 1);
    run_op("srl",   5'd7,  32'h8000_0000, 32'h24,        32'h0800_0000, 1'b0, 1);
    run_op("lui",   5'd18, 32'd7,         32'h0001_2345, 32'h1234_5000, 1'b0, 1);
    run_op("op0",   5'd0,  32'd5,         32'd6,         32'd0,         1'b0, 1);
    run_op("op31",  5'd31, 32'd5,         32'd6,         32'd0,         1'b0, 1);

    // Divide
    run_op("div",    5'd23, 32'd100,       32'd7,         32'd14,        1'b0, DIV_LAT);
    run_op("rem",    5'd25, 32'd100,       32'd7,         32'd2,         1'b0, DIV_LAT);
    run_op("divneg", 5'd23, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0, DIV_LAT);
    run_op("remneg", 5'd25, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0, DIV_LAT);
    run_op("div0",   5'd23, 32'd7,         32'd0,         32'hFFFF_FFFF, 1'b0, DIV_LAT);
    run_op("remu0",  5'd26, 32'd7,         32'd0,         32'd7,         1'b0, DIV_LAT);
    run_op("divovf", 5'd23, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, DIV_LAT);
    run_op("removf", 5'd25, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b0, DIV_LAT);
    run_op("divu",   5'd24, 32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC, 1'b0, DIV_LAT);

    // Multiply
    run_op("mulh",   5'd20, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         1'b0, MUL_LAT);
    run_op("mulhu",  5'd22, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, MUL_LAT);
    run_op("mulhsu", 5'd21, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 1'b0, MUL_LAT);
    run_op("mul",    5'd19, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFF1, 1'b0, MUL_LAT);
    run_op("mulbig", 5'd19, 32'h0001_0001, 32'h0001_0001, 32'h0002_0001, 1'b0, MUL_LAT);

    // Flush during DIVU with a competing request on the same cycle
    issue(5'd24, 32'd100, 32'd7);
    repeat (3) begin @(posedge clk); #1; end
    chk("fl_busy_before", 32'(busy), 32'd1);
    flush = 1'b1; in_valid = 1'b1; op = 5'd1; rs1 = 32'd5; rs2 = 32'd5;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_busy", 32'(busy), 32'd0);
    chk("fl_valid", 32'(out_valid), 32'd0);
    chk("fl_idle", 32'(in_ready), 32'd1);
    cnt = 0;
    repeat (40) begin
      if (out_valid) cnt++;
      @(posedge clk); #1;
    end
    chk("fl_no_result", 32'(cnt), 32'd0);
    run_op("fl_add", 5'd1, 32'd1, 32'd1, 32'd2, 1'b0, 1);

    // Reset in the middle of a divide
    issue(5'd23, 32'd100, 32'd7);
    repeat (9) begin @(posedge clk); #1; end
    chk("rd_busy_before", 32'(busy), 32'd1);
    chk("rd_res_before", result, 32'd2);
    rst = 1'b1;
    #1;
    chk("rd_valid", 32'(out_valid), 32'd0);
    chk("rd_busy", 32'(busy), 32'd0);
    chk("rd_result", result, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rd_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    run_op("rd_div", 5'd23, 32'd100, 32'd7, 32'd14, 1'b0, DIV_LAT);
    run_op("rd_rem", 5'd25, 32'd100, 32'd7, 32'd2,  1'b0, DIV_LAT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected end of test");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_muldiv_unit.md
Name: alu_muldiv_unit

Overview:
Parametrised, handshaked integer execute unit. Performs all base-integer ALU/branch operations plus RV32M-style multiply/divide/remainder. Base ops complete in one cycle; MUL/DIV ops use iterative datapaths. Sits between decode and writeback, replacing the purely combinational ALU on paths that need M-extension support or back-pressure.

Parameters:
XLEN, 32, operand/result width; power of two, at least 8.
SHAMT_W, $clog2(XLEN), number of rs2 bits used as shift amount.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  operation request valid.
in_ready  output  1  unit can accept a request.
op  input  5  operation code (encoding below).
rs1  input  XLEN  operand A.
rs2  input  XLEN  operand B.
flush  input  1  synchronous abort of any in-flight or held op.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts result.
result  output  XLEN  registered result.
branch_taken  output  1  registered branch condition (branch ops only, else 0).
busy  output  1  iterative op in progress.

Behaviour:
- Op codes: ADD=1, SUB=2, XOR=3, OR=4, AND=5, SLL=6, SRL=7, SRA=8, SLT=9, SLTU=10, BEQ=11, BNE=12, BLT=13, BGE=14, BLTU=15, BGEU=16, JAL=17 (rs1+rs2), LUI=18 (rs2<<12), MUL=19, MULH=20, MULHSU=21, MULHU=22, DIV=23, DIVU=24, REM=25, REMU=26.
- Any other code, including 0: result=0, branch_taken=0, 1-cycle latency.
- SLT/BLT/BGE are signed two's-complement. SLTU/BLTU/BGEU are unsigned. SRA is arithmetic.
- Shifts use rs2[SHAMT_W-1:0] only.
- Branch ops drive result=0. Non-branch ops drive branch_taken=0.
- FSM states: IDLE, BUSY, DONE.
  - in_ready=1 only in IDLE.
  - Handshake occurs on a cycle with in_valid && in_ready.
- IDLE, base op accepted: result and branch_taken registered at that edge; go to DONE. out_valid is high the next cycle (latency 1).
- IDLE, MUL*/DIV/REM op accepted: operands latched, iteration counter loaded with XLEN; go to BUSY with busy=1.
  - Counter decrements once per cycle.
  - When the counter reaches 0, result is registered and the FSM goes to DONE.
  - out_valid is first high XLEN+1 cycles after the accept edge.
- Multiplier: shift-add over magnitudes with sign fix-up.
  - MUL returns the low XLEN bits.
  - MULH, MULHSU and MULHU return the high XLEN bits (signed×signed, signed×unsigned, unsigned×unsigned).
- Divider: restoring, on magnitudes, with sign fix-up.
  - Quotient takes the sign of rs1 xor rs2; remainder takes the sign of rs1.
- Divide by zero, still the full XLEN+1 latency:
  - DIV/DIVU return all ones.
  - REM/REMU return rs1.
- Signed overflow (rs1 = most-negative, rs2 = -1):
  - DIV returns rs1.
  - REM returns 0.
- DONE: out_valid=1; result and branch_taken are held stable until out_valid && out_ready, then go to IDLE.
  - A new request cannot be accepted in the same cycle as the result handshake; the minimum issue interval is 2 cycles.
- flush=1, any state: next state IDLE, out_valid=0, busy=0, partial result discarded.
  - flush takes priority over a same-cycle in_valid, which is not accepted.
  - flush takes priority over a same-cycle out_ready.
- Reset (async, any time, including mid-divide): state=IDLE, result=0, branch_taken=0, out_valid=0, busy=0, counter=0.
  - in_ready=1 while rst is deasserted and the FSM is in IDLE.
- Inputs are sampled only at the accept edge. rs1/rs2/op may change freely afterwards.

Optional Feature:
Macro: ALU_FAST_MUL_EN.
- Defined: MUL, MULH, MULHSU and MULHU use a single-cycle combinational 2·XLEN product and behave exactly like base ops (latency 1, no BUSY). Divide stays iterative.
- Undefined: multiplies use the iterative shift-add path with XLEN+1 latency.
- Results are bit-identical in both builds.

Test Plan:
- Reset mid-DIV:
  - Stimulus: accept DIV 100/7, assert rst at cycle 10.
  - Response: out_valid=0, busy=0, result=0 immediately; in_ready=1 after release. Then DIV 100/7 gives 14 exactly 33 cycles after accept; REM 100/7 gives 2.
- Signed corner cases:
  - SLT rs1=0xFFFFFFFF, rs2=1 gives 1; SLTU with the same operands gives 0.
  - BGE rs1=-5, rs2=3 gives branch_taken=0; BGEU with the same operands gives 1.
  - SRA 0x80000000 by 0x21 (shamt 1) gives 0xC0000000.
- Divide edge cases:
  - DIV 7/0 gives 0xFFFFFFFF; REMU 7/0 gives 7.
  - DIV 0x80000000/0xFFFFFFFF gives 0x80000000; REM with the same operands gives 0.
  - All with the full latency.
- Multiply:
  - MULH 0xFFFFFFFF×0xFFFFFFFF gives 0; MULHU with the same operands gives 0xFFFFFFFE; MULHSU 0xFFFFFFFF×2 gives 0xFFFFFFFF.
  - Latency is 33 cycles without ALU_FAST_MUL_EN, 1 with it.
- Back-pressure:
  - ADD 3+4 with out_ready=0 for 5 cycles: result=7 held stable, in_ready=0 throughout.
  - Handshake on the 6th cycle, then in_ready=1 on the next cycle.
- Flush:
  - Assert flush during BUSY of DIVU, with in_valid=1 on the same cycle: no out_valid, request not accepted, IDLE next cycle.
  - A following ADD 1+1 returns 2.
